reload_counter_monitor: RTL and testbench

//  Passive observer at the output of a self-reloading up-counter. The counter counts up to MAX and

---
 rtl/reload_counter_monitor.sv | 129 ++++++++++++
 tb/tb_reload_counter_monitor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reload_counter_monitor.sv
// Passive observer of a self-reloading up-counter: reconstructs loads, flags wraps,
// tracks the active reload value and measures the wrap period.
module reload_counter_monitor #(
   parameter int WIDTH        = 4,
   parameter int RESET_RELOAD = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic [WIDTH-1:0] count_i,
   output logic             load_det_o,
   output logic             wrap_o,
   output logic [WIDTH-1:0] reload_val_o,
   output logic [WIDTH:0]   period_o,
   output logic             period_vld_o,
   output logic             locked_o
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      TRACK = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] MAX_C       = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE_W       = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH:0]   CNT_ONE     = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH:0]   CNT_MAX     = {(WIDTH+1){1'b1}};
   localparam logic [WIDTH-1:0] RELOAD_INIT = WIDTH'(RESET_RELOAD);

   state_t           state_r, state_s;
   logic [WIDTH-1:0] prev_r, prev_s;
   logic [WIDTH:0]   cnt_r, cnt_s;
   logic             known_r, known_s;
   logic [WIDTH-1:0] reload_r, reload_s;
   logic [WIDTH:0]   period_r, period_s;
   logic             load_det_r, load_det_s;
   logic             wrap_r, wrap_s;
   logic             period_vld_r, period_vld_s;
   logic             locked_r;
   logic [WIDTH-1:0] expected_s;

   // Next-state and next-output computation for one observed sample.
   always_comb begin
      state_s      = state_r;
      prev_s       = prev_r;
      cnt_s        = cnt_r;
      known_s      = known_r;
      reload_s     = reload_r;
      period_s     = period_r;
      load_det_s   = 1'b0;
      wrap_s       = 1'b0;
      period_vld_s = 1'b0;
      expected_s   = (prev_r == MAX_C) ? reload_r : (prev_r + ONE_W);
      case (state_r)
         IDLE: begin
            if (en_i) begin
               prev_s  = count_i;
               cnt_s   = CNT_ONE;
               known_s = 1'b0;
               state_s = TRACK;
            end else begin
               state_s = IDLE;
            end
         end
         TRACK: begin
            if (!en_i) begin
               state_s = IDLE;
            end else begin
               prev_s = count_i;
               // A wrap matches the expected value, so it can never also look like a load.
               if ((prev_r == MAX_C) && (count_i == reload_r)) begin
                  wrap_s       = 1'b1;
                  period_s     = cnt_r;
                  period_vld_s = known_r;
                  cnt_s        = CNT_ONE;
                  known_s      = 1'b1;
               end else if (count_i != expected_s) begin
                  load_det_s = 1'b1;
                  reload_s   = count_i;
                  cnt_s      = CNT_ONE;
                  known_s    = 1'b1;
               end else if (cnt_r != CNT_MAX) begin
                  cnt_s = cnt_r + CNT_ONE;
               end else begin
                  cnt_s = cnt_r;
               end
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and registered-output update with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         prev_r       <= {WIDTH{1'b0}};
         cnt_r        <= {(WIDTH+1){1'b0}};
         known_r      <= 1'b0;
         reload_r     <= RELOAD_INIT;
         period_r     <= {(WIDTH+1){1'b0}};
         load_det_r   <= 1'b0;
         wrap_r       <= 1'b0;
         period_vld_r <= 1'b0;
         locked_r     <= 1'b0;
      end else begin
         state_r      <= state_s;
         prev_r       <= prev_s;
         cnt_r        <= cnt_s;
         known_r      <= known_s;
         reload_r     <= reload_s;
         period_r     <= period_s;
         load_det_r   <= load_det_s;
         wrap_r       <= wrap_s;
         period_vld_r <= period_vld_s;
         locked_r     <= (state_s == TRACK);
      end
   end

   assign load_det_o   = load_det_r;
   assign wrap_o       = wrap_r;
   assign reload_val_o = reload_r;
   assign period_o     = period_r;
   assign period_vld_o = period_vld_r;
   assign locked_o     = locked_r;

endmodule

// File: tb/tb_reload_counter_monitor.sv
// Directed bench for reload_counter_monitor (WIDTH=4, RESET_RELOAD=0).
module tb_reload_counter_monitor;

   logic       clk = 1'b0;
   logic       reset;
   logic       en_i;
   logic [3:0] count_i;
   logic       load_det_o;
   logic       wrap_o;
   logic [3:0] reload_val_o;
   logic [4:0] period_o;
   logic       period_vld_o;
   logic       locked_o;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses;

   reload_counter_monitor #(.WIDTH(4), .RESET_RELOAD(0)) dut (
      .clk          (clk),
      .reset        (reset),
      .en_i         (en_i),
      .count_i      (count_i),
      .load_det_o   (load_det_o),
      .wrap_o       (wrap_o),
      .reload_val_o (reload_val_o),
      .period_o     (period_o),
      .period_vld_o (period_vld_o),
      .locked_o     (locked_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [3:0] v);
      @(negedge clk);
      count_i = v;
      @(posedge clk);
      #1;
   endtask

   // Drives lo..hi in order and totals every pulse seen along the way.
   task automatic run(input int lo, input int hi);
      pulses = 0;
      for (int i = lo; i <= hi; i++) begin
         step(4'(i));
         pulses += int'(load_det_o) + int'(wrap_o) + int'(period_vld_o);
      end
   endtask

   initial begin
      reset   = 1'b0;
      en_i    = 1'b1;
      count_i = 4'h0;
      #2;
      check_val("rst_load", load_det_o, 0);
      check_val("rst_wrap", wrap_o, 0);
      check_val("rst_vld", period_vld_o, 0);
      check_val("rst_lock", locked_o, 0);
      check_val("rst_reload", reload_val_o, 0);
      check_val("rst_period", period_o, 0);

      // 1: free run
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_val("t1_lock", locked_o, 1);
      check_val("t1_nopulse0", int'(load_det_o) + int'(wrap_o) + int'(period_vld_o), 0);
      run(1, 15);
      check_val("t1_run_a", pulses, 0);
      step(4'h0);
      check_val("t1_wrap1", wrap_o, 1);
      check_val("t1_vld1", period_vld_o, 0);
      check_val("t1_load1", load_det_o, 0);
      check_val("t1_reload", reload_val_o, 0);
      run(1, 15);
      check_val("t1_run_b", pulses, 0);
      step(4'h0);
      check_val("t1_wrap2", wrap_o, 1);
      check_val("t1_vld2", period_vld_o, 1);
      check_val("t1_period", period_o, 16);

      // 2: load of 5
      run(1, 7);
      check_val("t2_run_a", pulses, 0);
      step(4'h5);
      check_val("t2_load", load_det_o, 1);
      check_val("t2_wrap0", wrap_o, 0);
      check_val("t2_reload", reload_val_o, 5);
      step(4'h6);
      check_val("t2_load_1cyc", load_det_o, 0);
      run(7, 15);
      check_val("t2_run_b", pulses, 0);
      step(4'h5);
      check_val("t2_wrap", wrap_o, 1);
      check_val("t2_vld", period_vld_o, 1);
      check_val("t2_period", period_o, 11);

      // 3: reload = MAX
      step(4'h6);
      step(4'hF);
      check_val("t3_load", load_det_o, 1);
      check_val("t3_reload", reload_val_o, 15);
      step(4'hF);
      check_val("t3_wrap_a", wrap_o, 1);
      check_val("t3_noload_a", load_det_o, 0);
      check_val("t3_period_a", period_o, 1);
      check_val("t3_vld_a", period_vld_o, 1);
      step(4'hF);
      check_val("t3_wrap_b", wrap_o, 1);
      check_val("t3_period_b", period_o, 1);

      // 4: load at MAX instead of wrap
      step(4'h5);
      check_val("t4_load5", load_det_o, 1);
      check_val("t4_nowrap5", wrap_o, 0);
      check_val("t4_reload5", reload_val_o, 5);
      run(6, 15);
      check_val("t4_run_a", pulses, 0);
      step(4'h9);
      check_val("t4_load9", load_det_o, 1);
      check_val("t4_nowrap9", wrap_o, 0);
      check_val("t4_reload9", reload_val_o, 9);
      run(10, 15);
      check_val("t4_run_b", pulses, 0);
      step(4'h9);
      check_val("t4_wrap", wrap_o, 1);
      check_val("t4_vld", period_vld_o, 1);
      check_val("t4_period", period_o, 7);

      // 5: invisible load of 8 after 7
      step(4'h7);
      check_val("t5_load7", load_det_o, 1);
      step(4'h8);
      check_val("t5_inv_pulse", int'(load_det_o) + int'(wrap_o) + int'(period_vld_o), 0);
      check_val("t5_reload", reload_val_o, 7);

      // 6: disable, re-enable, then reset mid-count
      @(negedge clk);
      en_i    = 1'b0;
      count_i = 4'hC;
      @(posedge clk);
      #1;
      check_val("t6_dis_lock", locked_o, 0);
      check_val("t6_dis_pulse", int'(load_det_o) + int'(wrap_o) + int'(period_vld_o), 0);
      check_val("t6_dis_reload", reload_val_o, 7);
      check_val("t6_dis_period", period_o, 7);
      step(4'h3);
      check_val("t6_dis_pulse2", int'(load_det_o) + int'(wrap_o) + int'(period_vld_o), 0);
      @(negedge clk);
      en_i    = 1'b1;
      count_i = 4'hE;
      @(posedge clk);
      #1;
      check_val("t6_en_lock", locked_o, 1);
      check_val("t6_en_pulse", int'(load_det_o) + int'(wrap_o) + int'(period_vld_o), 0);
      step(4'hF);
      check_val("t6_f_pulse", int'(load_det_o) + int'(wrap_o) + int'(period_vld_o), 0);
      step(4'h7);
      check_val("t6_wrap", wrap_o, 1);
      check_val("t6_wrap_novld", period_vld_o, 0);
      reset = 1'b0;
      #1;
      check_val("t6_rst_wrap", wrap_o, 0);
      check_val("t6_rst_lock", locked_o, 0);
      check_val("t6_rst_reload", reload_val_o, 0);
      check_val("t6_rst_period", period_o, 0);
      @(negedge clk);
      reset   = 1'b1;
      count_i = 4'h3;
      @(posedge clk);
      #1;
      check_val("t6_relock", locked_o, 1);
      run(4, 15);
      check_val("t6_run_a", pulses, 0);
      step(4'h0);
      check_val("t6_wrap_a", wrap_o, 1);
      check_val("t6_novld_a", period_vld_o, 0);
      run(1, 15);
      check_val("t6_run_b", pulses, 0);
      step(4'h0);
      check_val("t6_vld_b", period_vld_o, 1);
      check_val("t6_period_b", period_o, 16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
